// File: rtl/dct_2d_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : dct_2d_sequencer_if
// Description : Handshake, core-address and buffer-address bundle between the
//               2-D DCT sequencer, its 1-D core, buffers and upstream control.
// Revision    : 1.0 - initial release
// ============================================================================
interface dct_2d_sequencer_if;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic       core_nreset;
    logic [2:0] core_fetch_addr;
    logic [2:0] core_result_addr;
    logic       core_result_wren;
    logic [5:0] src_raddr;
    logic       src_sel;
    logic [5:0] dst_waddr;
    logic       dst_sel;
    logic       dst_wren;
    logic       pass;
    logic [2:0] vector_idx;

    modport master (
        output start, abort, core_fetch_addr, core_result_addr, core_result_wren,
        input  busy, done, core_nreset, src_raddr, src_sel, dst_waddr, dst_sel,
               dst_wren, pass, vector_idx
    );

    modport slave (
        input  start, abort, core_fetch_addr, core_result_addr, core_result_wren,
        output busy, done, core_nreset, src_raddr, src_sel, dst_waddr, dst_sel,
               dst_wren, pass, vector_idx
    );
endinterface
`default_nettype wire

// File: rtl/dct_2d_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dct_2d_sequencer
// Description : Drives one 1-D DCT core through 8 row + 8 column vectors with
//               transposed buffer addressing. Optional cycle counter enabled
//               by defining DCT2D_SEQ_CYCLE_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dct_2d_sequencer #(
    parameter int CORE_RESET_CYCLES = 2,
    parameter int WRITES_PER_VECTOR = 8,
    parameter int DRAIN_CYCLES      = 1
) (
    input  wire               clk,
    input  wire               rst_n,
`ifdef DCT2D_SEQ_CYCLE_COUNT_EN
    output logic [15:0]       o_cycle_count,
`endif
    dct_2d_sequencer_if.slave bus
);
    localparam int c_DLY_MAX = (CORE_RESET_CYCLES > DRAIN_CYCLES) ? CORE_RESET_CYCLES : DRAIN_CYCLES;
    localparam int c_DLY_W   = $clog2(c_DLY_MAX + 1);
    localparam int c_WCNT_W  = $clog2(WRITES_PER_VECTOR + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CORE_RST = 3'd1,
        S_RUN      = 3'd2,
        S_DRAIN    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_pass, w_pass_nxt;
    logic [2:0]          r_vec, w_vec_nxt;
    logic [c_WCNT_W-1:0] r_wcnt, w_wcnt_nxt;
    logic [c_DLY_W-1:0]  r_dly, w_dly_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pass  <= 1'b0;
            r_vec   <= 3'd0;
            r_wcnt  <= '0;
            r_dly   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pass  <= w_pass_nxt;
            r_vec   <= w_vec_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_dly   <= w_dly_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pass_nxt  = r_pass;
        w_vec_nxt   = r_vec;
        w_wcnt_nxt  = r_wcnt;
        w_dly_nxt   = r_dly;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_CORE_RST;
                    w_pass_nxt  = 1'b0;
                    w_vec_nxt   = 3'd0;
                    w_wcnt_nxt  = '0;
                    w_dly_nxt   = '0;
                end
            end
            S_CORE_RST: begin
                if (r_dly == c_DLY_W'(CORE_RESET_CYCLES - 1)) begin
                    w_state_nxt = S_RUN;
                    w_dly_nxt   = '0;
                end else begin
                    w_dly_nxt = r_dly + 1'b1;
                end
            end
            S_RUN: begin
                // The final write is still forwarded; the vector closes on the following edge.
                if (bus.core_result_wren) begin
                    w_wcnt_nxt = r_wcnt + 1'b1;
                    if (r_wcnt == c_WCNT_W'(WRITES_PER_VECTOR - 1)) begin
                        w_state_nxt = S_DRAIN;
                        w_dly_nxt   = '0;
                    end
                end
            end
            S_DRAIN: begin
                if (r_dly == c_DLY_W'(DRAIN_CYCLES - 1)) begin
                    w_dly_nxt  = '0;
                    w_wcnt_nxt = '0;
                    if (r_vec != 3'd7) begin
                        w_vec_nxt   = r_vec + 3'd1;
                        w_state_nxt = S_CORE_RST;
                    end else if (!r_pass) begin
                        w_pass_nxt  = 1'b1;
                        w_vec_nxt   = 3'd0;
                        w_state_nxt = S_CORE_RST;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_dly_nxt = r_dly + 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_pass_nxt  = 1'b0;
                w_vec_nxt   = 3'd0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_pass_nxt  = 1'b0;
                w_vec_nxt   = 3'd0;
            end
        endcase
        if (bus.abort) begin
            w_state_nxt = S_IDLE;
            w_pass_nxt  = 1'b0;
            w_vec_nxt   = 3'd0;
            w_wcnt_nxt  = '0;
            w_dly_nxt   = '0;
        end
    end

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = (r_state == S_DONE);
    assign bus.core_nreset = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign bus.dst_wren    = bus.core_result_wren && (r_state == S_RUN);
    assign bus.pass        = r_pass;
    assign bus.vector_idx  = r_vec;
    assign bus.src_sel     = r_pass;
    assign bus.dst_sel     = r_pass;
    // Column pass swaps the index halves so pass-0 rows are read back as columns.
    assign bus.src_raddr   = r_pass ? {bus.core_fetch_addr, r_vec}  : {r_vec, bus.core_fetch_addr};
    assign bus.dst_waddr   = r_pass ? {bus.core_result_addr, r_vec} : {r_vec, bus.core_result_addr};

`ifdef DCT2D_SEQ_CYCLE_COUNT_EN
    logic [15:0] r_cycle_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_count <= 16'd0;
        end else if ((r_state == S_IDLE) && bus.start && !bus.abort) begin
            r_cycle_count <= 16'd0;
        end else if ((r_state != S_IDLE) && (r_cycle_count != 16'hffff)) begin
            r_cycle_count <= r_cycle_count + 16'd1;
        end
    end

    assign o_cycle_count = r_cycle_count;
`endif
endmodule
`default_nettype wire

// File: tb/tb_dct_2d_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dct_2d_sequencer
// Description : Self-checking bench for dct_2d_sequencer with a behavioural
//               1-D core stand-in and a cycle-schedule reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dct_2d_sequencer;
    logic clk;
    logic rst_n;
    dct_2d_sequencer_if bus();
`ifdef DCT2D_SEQ_CYCLE_COUNT_EN
    logic [15:0] cycle_count;
`endif

    dct_2d_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef DCT2D_SEQ_CYCLE_COUNT_EN
        .o_cycle_count(cycle_count),
`endif
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       pass;
        logic [2:0] vec;
        logic [2:0] fetch;
        logic [2:0] res;
        logic [5:0] src;
        logic [5:0] dst;
    } addr_vec_t;

    addr_vec_t tab[5];
    int n_checks = 0;
    int n_pass   = 0;
    int t        = 0;   // cycle number relative to start acceptance
    int k        = 0;   // cycles since core_nreset rose
    bit active   = 0;
    int n_wr     = 0;
    int n_done   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    function automatic void model_pv(output logic p, output logic [2:0] v);
        p = 1'b0;
        v = 3'd0;
        if (active && t >= 1 && t <= 240) begin
            p = ((t - 1) / 15) >= 8;
            v = 3'(((t - 1) / 15) % 8);
        end else if (active && t == 241) begin
            p = 1'b1;
            v = 3'd7;
        end
    endfunction

    // Reference schedule: each vector is 2 reset + 12 run + 1 drain cycles, then one DONE cycle.
    task automatic check_cycle();
        logic       e_busy, e_done, e_cnr, e_pass, e_run, e_wren;
        logic [2:0] e_vec;
        logic [5:0] e_src, e_dst;
        logic [21:0] e_all, a_all;
        int o;
        e_busy = 0; e_done = 0; e_cnr = 0; e_run = 0;
        model_pv(e_pass, e_vec);
        if (active && t >= 1 && t <= 240) begin
            o      = (t - 1) % 15;
            e_busy = 1'b1;
            e_cnr  = (o >= 2);
            e_run  = (o >= 2) && (o <= 13);
        end else if (active && t == 241) begin
            e_busy = 1'b1;
            e_done = 1'b1;
        end
        e_src  = e_pass ? {bus.core_fetch_addr, e_vec}  : {e_vec, bus.core_fetch_addr};
        e_dst  = e_pass ? {bus.core_result_addr, e_vec} : {e_vec, bus.core_result_addr};
        e_wren = bus.core_result_wren && e_run;
        e_all  = {e_busy, e_done, e_cnr, e_pass, e_vec, e_src, e_dst, e_pass, e_pass, e_wren};
        a_all  = {bus.busy, bus.done, bus.core_nreset, bus.pass, bus.vector_idx, bus.src_raddr,
                  bus.dst_waddr, bus.src_sel, bus.dst_sel, bus.dst_wren};
        chk($sformatf("cycle t=%0d active=%0d", t, active), 32'(a_all), 32'(e_all));
        if (bus.dst_wren) n_wr++;
        if (bus.done) n_done++;
    endtask

    // Behavioural core: 8 writes starting 4 cycles after release, spurious strobes outside RUN.
    task automatic step();
        @(posedge clk);
        #1;
        t++;
        k = bus.core_nreset ? k + 1 : 0;
        bus.core_fetch_addr  = 3'($urandom);
        bus.core_result_addr = 3'($urandom);
        bus.core_result_wren = (k >= 5 && k <= 12) || (k == 13) || (k == 0 && $urandom_range(0, 1) == 1);
        bus.start = active && t >= 1 && t <= 241 && ((t == 50) || $urandom_range(0, 15) == 0);
        bus.abort = 1'b0;
        #1;
    endtask

    task automatic run_to(input int limit);
        while (t < limit) begin
            step();
            check_cycle();
        end
    endtask

    task automatic begin_xfer();
        bus.start = 1'b1;
        t      = 0;
        active = 1'b1;
        n_wr   = 0;
        n_done = 0;
        check_cycle();
    endtask

    task automatic end_checks(input string tag);
        chk({tag, " dst_wren pulses"}, 32'(n_wr), 32'd128);
        chk({tag, " done pulses"}, 32'(n_done), 32'd1);
`ifdef DCT2D_SEQ_CYCLE_COUNT_EN
        chk({tag, " cycle_count"}, 32'(cycle_count), 32'd241);
`endif
    endtask

    initial begin
        tab[0] = '{pass: 1'b0, vec: 3'd5, fetch: 3'd3, res: 3'd6, src: 6'o53, dst: 6'o56};
        tab[1] = '{pass: 1'b0, vec: 3'd7, fetch: 3'd1, res: 3'd2, src: 6'o71, dst: 6'o72};
        tab[2] = '{pass: 1'b1, vec: 3'd0, fetch: 3'd7, res: 3'd4, src: 6'o70, dst: 6'o40};
        tab[3] = '{pass: 1'b1, vec: 3'd5, fetch: 3'd3, res: 3'd6, src: 6'o35, dst: 6'o65};
        tab[4] = '{pass: 1'b1, vec: 3'd7, fetch: 3'd0, res: 3'd0, src: 6'o07, dst: 6'o07};

        rst_n = 1'b0;
        bus.start = 0; bus.abort = 0;
        bus.core_fetch_addr = 0; bus.core_result_addr = 0; bus.core_result_wren = 0;
        #3;
        check_cycle();
`ifdef DCT2D_SEQ_CYCLE_COUNT_EN
        chk("reset cycle_count", 32'(cycle_count), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_cycle();

        // Plain transform.
        begin_xfer();
        run_to(242);
        end_checks("full");

        // Address transposition table applied during a live transform.
        begin_xfer();
        for (int i = 0; i < 5; i++) begin
            logic p;
            logic [2:0] v;
            int guard = 0;
            model_pv(p, v);
            while (!(p == tab[i].pass && v == tab[i].vec) && guard < 300) begin
                step();
                check_cycle();
                model_pv(p, v);
                guard++;
            end
            if (guard >= 300) chk($sformatf("table[%0d] wait timeout", i), 32'd1, 32'd0);
            bus.core_fetch_addr  = tab[i].fetch;
            bus.core_result_addr = tab[i].res;
            #1;
            chk($sformatf("table[%0d] src/dst/sel", i),
                32'({bus.src_raddr, bus.dst_waddr, bus.src_sel, bus.dst_sel}),
                32'({tab[i].src, tab[i].dst, tab[i].pass, tab[i].pass}));
            check_cycle();
        end
        run_to(242);
        end_checks("table");

        // Abort in pass 1 vector 2 RUN.
        begin_xfer();
        run_to(156);
        bus.abort = 1'b1;
        check_cycle();
        active = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check_cycle();
        end
        chk("abort done pulses", 32'(n_done), 32'd0);
        begin_xfer();
        run_to(242);
        end_checks("post-abort");

        // Asynchronous reset mid-RUN.
        begin_xfer();
        run_to(100);
        rst_n = 1'b0;
        active = 1'b0;
        #1;
        check_cycle();
`ifdef DCT2D_SEQ_CYCLE_COUNT_EN
        chk("async reset cycle_count", 32'(cycle_count), 32'd0);
`endif
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_cycle();
        end
        chk("reset done pulses", 32'(n_done), 32'd0);
        begin_xfer();
        run_to(242);
        end_checks("post-reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dct_2d_sequencer.md
Name: dct_2d_sequencer

Overview:
- Sequences one `loeffler_dct_8` 1-D core through a full 8x8 2-D DCT.
- Pass 0 runs the 8 rows: input-block buffer -> transpose buffer.
- Pass 1 runs the 8 columns: transpose buffer -> output buffer.
- The block holds the core in reset between vectors, translates the core's 3-bit fetch/result addresses into 6-bit buffer addresses with row/column transposition, counts core writes to detect vector completion, and gives the upstream JPEG pipeline a start/busy/done handshake.

Parameters:
- CORE_RESET_CYCLES, 2, cycles core_nreset is held low before each vector (min 1).
- WRITES_PER_VECTOR, 8, core_result_wren pulses that complete one vector.
- DRAIN_CYCLES, 1, idle cycles after the last write of a vector before the next core reset (min 1).

Ports:
- clock  in  1  system clock; all state on rising edge.
- nreset  in  1  asynchronous active-low reset.
- start  in  1  begin a 2-D transform; sampled only in IDLE.
- abort  in  1  synchronous; returns to IDLE from any state, no done pulse.
- busy  out  1  high in all states except IDLE.
- done  out  1  one-cycle pulse when pass 1 vector 7 completes.
- core_nreset  out  1  active-low reset to 1-D core; high only in RUN and DRAIN.
- core_fetch_addr  in  3  core's element read address.
- core_result_addr  in  3  core's result write address.
- core_result_wren  in  1  core's result write strobe.
- src_raddr  out  6  source buffer read address.
- src_sel  out  1  0 = input-block buffer, 1 = transpose buffer.
- dst_waddr  out  6  destination buffer write address.
- dst_sel  out  1  0 = transpose buffer, 1 = output buffer.
- dst_wren  out  1  gated write strobe to destination.
- pass  out  1  0 = row pass, 1 = column pass.
- vector_idx  out  3  current row/column index.

Behaviour:
- Reset (nreset low, async): state=IDLE, busy=0, done=0, core_nreset=0, pass=0, vector_idx=0, write count=0, delay counter=0.
  - src_sel=0 and dst_sel=0.
  - dst_wren=0.
  - Reset mid-transform discards all progress.
- States: IDLE, CORE_RST, RUN, DRAIN, DONE.
- IDLE: core_nreset=0.
  - start=1 -> CORE_RST, with pass=0, vector_idx=0, write count=0.
  - start is ignored in every other state.
- CORE_RST: core_nreset=0 for exactly CORE_RESET_CYCLES cycles, then RUN. Write count is cleared on entry.
- RUN: core_nreset=1. Each cycle with core_result_wren=1 increments write count.
  - The WRITES_PER_VECTOR-th write itself is forwarded as normal.
  - The state then moves to DRAIN on the next edge.
- DRAIN: core_nreset=1 for DRAIN_CYCLES cycles. Then:
  - vector_idx<7: vector_idx+1, -> CORE_RST.
  - vector_idx==7, pass==0: pass=1, vector_idx=0, -> CORE_RST.
  - vector_idx==7, pass==1: -> DONE.
- DONE: done=1 for this single cycle, busy=1, then IDLE. pass and vector_idx return to 0 on entry to IDLE.
- abort: has priority over all transitions except nreset.
  - Next state is IDLE; core_nreset drops the following cycle.
  - done is not pulsed.
- Address mapping (combinational, zero latency, valid in all states):
  - pass 0: src_raddr={vector_idx, core_fetch_addr}; dst_waddr={vector_idx, core_result_addr}.
  - pass 1: src_raddr={core_fetch_addr, vector_idx}; dst_waddr={core_result_addr, vector_idx}.
  - src_sel=pass; dst_sel=pass.
- dst_wren = core_result_wren AND state==RUN.
  - Strobes in CORE_RST, DRAIN, DONE or IDLE are suppressed and not counted.
- Simultaneous start and abort in IDLE: abort wins, stay IDLE.
- Total transform length: 16 vectors, each CORE_RESET_CYCLES + (RUN length) + DRAIN_CYCLES cycles, plus 1 DONE cycle.

Optional Feature:
- Macro: DCT2D_SEQ_CYCLE_COUNT_EN.
- When defined: adds output cycle_count (16 bits).
  - Cleared to 0 when start is accepted.
  - Increments every cycle while busy=1, saturating at 16'hffff.
  - Holds its value in IDLE, so it reads total transform latency after done.
  - Cleared by nreset; unaffected by abort.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset then start.
  - Stimulus: behavioural core model that asserts wren once per cycle for 8 cycles, starting 4 cycles after core_nreset rises.
  - Required: 16 vectors in order (pass0 v0..7, pass1 v0..7), exactly 128 dst_wren pulses, one done pulse.
  - With defaults, done at cycle 16*(2+12+1)+1=241 after start acceptance; cycle_count=241 when enabled.
- Address transposition.
  - Stimulus: pass 1, vector_idx=5, core_fetch_addr=3, core_result_addr=6.
  - Required: src_raddr=6'o35 (29), dst_waddr=6'o65 (53), src_sel=1, dst_sel=1.
  - Same inputs in pass 0 with vector_idx=5: src_raddr=6'o53, dst_waddr=6'o56.
- Spurious core write.
  - Stimulus: core_result_wren pulsed during CORE_RST and during DRAIN.
  - Required: dst_wren=0 and write count unchanged; vector still ends after 8 RUN writes.
- Start while busy.
  - Stimulus: start pulsed during pass 0 vector 3.
  - Required: no restart; vector_idx continues 4; single done at the normal time.
- Abort.
  - Stimulus: abort during pass 1 vector 2 RUN.
  - Required: IDLE next cycle, busy=0, core_nreset=0, done never asserted.
  - A subsequent start runs a full 241-cycle transform from pass 0 vector 0.
- Async reset mid-transform.
  - Stimulus: nreset low for 3 ns mid-RUN.
  - Required: outputs reach reset values before the next clock edge; no done; start afterwards behaves as after power-up.
